// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with FIFO replacement
//
// Sits between instruction fetch and the RAM controller. Lookups are
// combinational; a miss refills the whole line one 32-bit word per RAM beat
// into the victim way (lowest invalid way, else the set's FIFO pointer).
//
// Optional feature macro: ICACHE_FLUSH_EN adds icache_flush_in, which
// invalidates every line and aborts any refill in progress.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   rdy_in                    global enable; low freezes all state
//   if_icache_en_in/addr_in   fetch request and byte address
//   icache_if_hit_out/inst_out  hit flag and instruction word (0 on no hit)
//   icache_ramctrl_en_out/addr_out  word read request to RAM controller
//   ramctrl_icache_rdy_in/data_in   one-cycle data-valid pulse and word
//   icache_flush_in           invalidate all lines (ICACHE_FLUSH_EN only)
module icache_assoc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WAYS           = 2,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_icache_en_in,
  input  logic [ADDR_WIDTH-1:0] if_icache_addr_in,
  output logic                  icache_if_hit_out,
  output logic [31:0]           icache_if_inst_out,
  output logic                  icache_ramctrl_en_out,
  output logic [ADDR_WIDTH-1:0] icache_ramctrl_addr_out,
  input  logic                  ramctrl_icache_rdy_in,
  input  logic [31:0]           ramctrl_icache_data_in
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic                  icache_flush_in
`endif
);

  localparam int OFF   = $clog2(WORDS_PER_LINE) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF - IDX_W;
  // Way and beat indices keep at least one bit so degenerate configs elaborate.
  localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                   state;
  logic [CW-1:0]            beat;
  logic [TAG_W-1:0]         lat_tag;
  logic [IDX_W-1:0]         lat_idx;
  logic [WB-1:0]            victim_q;

  logic [WAYS-1:0]          valid    [SETS];
  logic [WB-1:0]            fifo_ptr [SETS];
  logic [TAG_W-1:0]         tag_mem  [WAYS][SETS];
  logic [31:0]              data_mem [WAYS][SETS][WORDS_PER_LINE];

  logic                     flush;
  logic [TAG_W-1:0]         req_tag;
  logic [IDX_W-1:0]         req_idx;
  logic [CW-1:0]            req_word;
  logic                     any_match;
  logic [31:0]              match_word;
  logic [WB-1:0]            victim;
  logic                     beat_last;
  logic                     beat_write;
  logic [ADDR_WIDTH-1:0]    line_base;
  logic                     unused_addr_bits;

`ifdef ICACHE_FLUSH_EN
  assign flush = icache_flush_in;
`else
  assign flush = 1'b0;
`endif

  assign req_tag          = if_icache_addr_in[ADDR_WIDTH-1:OFF+IDX_W];
  assign req_idx          = if_icache_addr_in[OFF+IDX_W-1:OFF];
  assign unused_addr_bits = ^if_icache_addr_in[1:0];

  generate
    if (WORDS_PER_LINE > 1) begin : g_word_sel
      assign req_word = if_icache_addr_in[OFF-1:2];
    end else begin : g_single_word
      assign req_word = 1'b0;
    end
  endgenerate

  // Tag compare across all ways of the indexed set; at most one way matches.
  always_comb begin
    any_match  = 1'b0;
    match_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
        any_match  = 1'b1;
        match_word = data_mem[w][req_idx][req_word];
      end
    end
  end

  // Scan downwards so the lowest-index invalid way wins.
  always_comb begin
    victim = fifo_ptr[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) victim = WB'(w);
    end
  end

  assign icache_if_hit_out  = (state == IDLE) && if_icache_en_in && rdy_in &&
                              any_match && !flush;
  assign icache_if_inst_out = icache_if_hit_out ? match_word : 32'h0;

  assign line_base               = {lat_tag, lat_idx, {OFF{1'b0}}};
  assign icache_ramctrl_en_out   = (state == REFILL);
  assign icache_ramctrl_addr_out = (state == REFILL) ?
                                   line_base + (ADDR_WIDTH'(beat) << 2) : '0;

  assign beat_last  = (beat == CW'(WORDS_PER_LINE - 1));
  assign beat_write = (state == REFILL) && rdy_in && ramctrl_icache_rdy_in && !flush;

  // Control state, valid bits and FIFO pointers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      beat     <= '0;
      lat_tag  <= '0;
      lat_idx  <= '0;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]    <= '0;
        fifo_ptr[s] <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        state <= IDLE;
        beat  <= '0;
        for (int s = 0; s < SETS; s++) begin
          valid[s]    <= '0;
          fifo_ptr[s] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (if_icache_en_in && !any_match) begin
              lat_tag  <= req_tag;
              lat_idx  <= req_idx;
              victim_q <= victim;
              beat     <= '0;
              state    <= REFILL;
            end
          end
          REFILL: begin
            if (ramctrl_icache_rdy_in) begin
              if (beat_last) begin
                valid[lat_idx][victim_q] <= 1'b1;
                fifo_ptr[lat_idx] <= (WAYS == 1) ? '0 : fifo_ptr[lat_idx] + 1'b1;
                beat  <= '0;
                state <= IDLE;
              end else begin
                beat <= beat + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tag and data arrays are not reset; valid bits guard them.
  always_ff @(posedge clk_in) begin
    if (beat_write) begin
      data_mem[victim_q][lat_idx][beat] <= ramctrl_icache_data_in;
      if (beat_last) tag_mem[victim_q][lat_idx] <= lat_tag;
    end
  end

endmodule
